ldd_enc: RTL and testbench

Sequential command encoder that is the transmit-side counterpart of the `ldd` control decoder. Upstream logic raises one request line per command class. The block queues these requests with a per-class qualifier and arbitrates them round-robin. It then emits one packed command (3-bit opcode plus 6 qualifier bits) per valid/ready handshake, in the format the decoder consumes. The block sits between the command-issuing control logic and the decoder input bus.

---
 rtl/ldd_enc.sv | 157 +++++++++++++++
 tb/tb_ldd_enc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ldd_enc.sv
// Transmit-side command encoder for the ldd decoder: queues one request per
// class with its qualifier and emits them round-robin over a valid/ready port.

module ldd_enc_cls (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic       gnt_i,
    input  logic [5:0] qual_i,
    output logic       pend_o,
    output logic [5:0] qreg_o,
    output logic       drop_o
);
    logic       pend_q, pend_d;
    logic [5:0] qreg_q, qreg_d;
    logic       load;

    // A grant frees the slot before a same-cycle request claims it again.
    assign load   = req_i && (!pend_q || gnt_i);
    assign drop_o = req_i && pend_q && !gnt_i;

    always_comb begin
        pend_d = pend_q;
        qreg_d = qreg_q;
        if (gnt_i) pend_d = 1'b0;
        if (load) begin
            pend_d = 1'b1;
            qreg_d = qual_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            qreg_q <= '0;
        end else begin
            pend_q <= pend_d;
            qreg_q <= qreg_d;
        end
    end

    assign pend_o = pend_q;
    assign qreg_o = qreg_q;
endmodule

module ldd_enc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [5:0] qual,
    input  logic       out_rdy,
    input  logic       clr_ovf,
    output logic       out_vld,
    output logic [2:0] out_op,
    output logic [5:0] out_qual,
    output logic [7:0] pend,
    output logic       ovf
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [2:0]      rr_q, rr_d;
    logic [2:0]      op_q, op_d;
    logic [5:0]      qual_q, qual_d;
    logic            ovf_q, ovf_d;
    logic [2:0]      win;
    logic            grant;
    logic [7:0]      gnt_vec;
    logic [7:0]      drop;
    logic [7:0][5:0] qreg;

    for (genvar k = 0; k < 8; k++) begin : g_cls
        ldd_enc_cls u_cls (
            .clk    (clk),
            .rst_n  (rst_n),
            .req_i  (req[k]),
            .gnt_i  (gnt_vec[k]),
            .qual_i (qual),
            .pend_o (pend[k]),
            .qreg_o (qreg[k]),
            .drop_o (drop[k])
        );
    end

    // First pending class at or after the pointer, wrapping mod 8.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        win   = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 8; i++) begin
            idx = rr_q + 3'(i);
            if (!found && pend[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    grant   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    if (|pend) grant = 1'b1;
                    else       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_vec = '0;
        rr_d    = rr_q;
        op_d    = op_q;
        qual_d  = qual_q;
        if (grant) begin
            gnt_vec[win] = 1'b1;
            rr_d         = win + 3'd1;
            op_d         = win;
            qual_d       = qreg[win];
        end
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (|drop)   ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            op_q    <= '0;
            qual_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            qual_q  <= qual_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_vld  = (state_q == SEND);
    assign out_op   = op_q;
    assign out_qual = qual_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_ldd_enc.sv
// Directed bench for ldd_enc: expected commands go into a scoreboard queue,
// a negedge monitor pops and compares on every accepted handshake.

module tb_ldd_enc;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [5:0] qual;
    logic       out_rdy;
    logic       clr_ovf;
    logic       out_vld;
    logic [2:0] out_op;
    logic [5:0] out_qual;
    logic [7:0] pend;
    logic       ovf;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] q;
    } cmd_t;

    cmd_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    ldd_enc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .qual     (qual),
        .out_rdy  (out_rdy),
        .clr_ovf  (clr_ovf),
        .out_vld  (out_vld),
        .out_op   (out_op),
        .out_qual (out_qual),
        .pend     (pend),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [5:0] q);
        cmd_t c;
        c.op = op;
        c.q  = q;
        sb.push_back(c);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_cmd: got op=%0d qual=%0h with empty queue", out_op, out_qual);
            end else begin
                cmd_t e;
                e = sb.pop_front();
                if (out_op !== e.op || out_qual !== e.q) begin
                    errs++;
                    $display("FAIL sb_cmd: got op=%0d qual=%0h expected op=%0d qual=%0h",
                             out_op, out_qual, e.op, e.q);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = '0; qual = '0; out_rdy = 1'b1; clr_ovf = 1'b0;
        #1;
        chk("rst_vld", out_vld, 0);
        chk("rst_pend", pend, 0);
        chk("rst_op_qual", {out_op, out_qual}, 0);
        chk("rst_ovf", ovf, 0);
        tick(); tick();
        rst_n = 1'b1;

        // single request, idle latency
        req = 8'h10; qual = 6'h2A; push(3'd4, 6'h2A);
        tick();
        chk("lat_pend", pend, 8'h10);
        chk("lat_vld0", out_vld, 0);
        req = '0;
        tick();
        chk("lat_vld1", out_vld, 1);
        chk("lat_op", out_op, 4);
        chk("lat_qual", out_qual, 6'h2A);
        tick();
        chk("lat_vld_drop", out_vld, 0);

        // rr=5: class 7 moves pointer to 0
        req = 8'h80; qual = 6'h3C; push(3'd7, 6'h3C);
        tick(); req = '0; tick();
        chk("rr5_op", out_op, 7);
        tick();

        // all classes at once, back-to-back without bubbles
        req = 8'hFF; qual = 6'h01;
        for (int i = 0; i < 8; i++) push(3'(i), 6'h01);
        tick();
        chk("ff_pend", pend, 8'hFF);
        req = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ff_burst", {out_vld, out_op}, {1'b1, 3'(i)});
        end
        tick();
        chk("ff_done", {out_vld, pend}, 9'h0);

        // backpressure
        out_rdy = 1'b0;
        req = 8'h08; qual = 6'h33; push(3'd3, 6'h33); push(3'd5, 6'h05);
        tick(); req = '0; tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin req = 8'h20; qual = 6'h05; end
            tick();
            req = '0;
            chk("bp_hold", {out_vld, out_op, out_qual}, {1'b1, 3'd3, 6'h33});
        end
        chk("bp_pend", pend, 8'h20);
        out_rdy = 1'b1;
        tick();
        chk("bp_next", {out_vld, out_op, out_qual}, {1'b1, 3'd5, 6'h05});
        tick();
        chk("bp_idle", out_vld, 0);

        // wrap: rr=6, pend=81, re-request 7 on its grant edge
        req = 8'h81; qual = 6'h07;
        push(3'd7, 6'h07); push(3'd0, 6'h07); push(3'd7, 6'h17);
        tick();
        chk("wr_pend", pend, 8'h81);
        req = 8'h80; qual = 6'h17;
        tick();
        req = '0;
        chk("wr_g7", {out_op, out_qual}, {3'd7, 6'h07});
        chk("wr_pend_keep", pend, 8'h81);
        chk("wr_no_ovf", ovf, 0);
        tick();
        chk("wr_g0", {out_op, pend}, {3'd0, 8'h80});
        tick();
        chk("wr_g7b", {out_op, out_qual, pend}, {3'd7, 6'h17, 8'h00});
        tick();

        // overflow, set beats clear
        out_rdy = 1'b0;
        req = 8'h02; qual = 6'h01; push(3'd1, 6'h01); push(3'd2, 6'h11);
        tick();
        req = 8'h04; qual = 6'h11;
        tick();
        req = 8'h04; qual = 6'h22;
        tick();
        chk("ov_set", ovf, 1);
        chk("ov_pend", pend, 8'h04);
        req = 8'h04; qual = 6'h33; clr_ovf = 1'b1;
        tick();
        chk("ov_set_wins", ovf, 1);
        req = '0;
        tick();
        chk("ov_clr", ovf, 0);
        clr_ovf = 1'b0; out_rdy = 1'b1;
        tick();
        chk("ov_qual", {out_op, out_qual}, {3'd2, 6'h11});
        tick();

        // async reset mid-transfer
        out_rdy = 1'b0;
        req = 8'h30; qual = 6'h3F;
        tick(); req = '0; tick();
        chk("ar_pre", {out_vld, out_op, pend}, {1'b1, 3'd4, 8'h20});
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", out_vld, 0);
        chk("ar_outs", {out_op, out_qual, pend, ovf}, 0);
        tick();
        rst_n = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_quiet", out_vld, 0);
        end
        req = 8'h40; qual = 6'h26; push(3'd6, 6'h26);
        tick(); req = '0; tick();
        chk("ar_new", {out_vld, out_op, out_qual}, {1'b1, 3'd6, 6'h26});
        tick(); tick();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
